// File: rtl/spu_pipe.sv
// rtl/spu_pipe.sv - 4-stage IEEE-754 activation pipeline (sigmoid/tanh/ReLU/identity)
// Optional feature macro: SPU_SAT_STATS_EN builds the saturation counter behind sat_count.
module spu_pipe #(
  parameter int FRAC_BITS = 16,
  parameter int INT_BITS  = 8,
  parameter int TAG_W     = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_data,
  input  logic [1:0]       in_mode,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_data,
  output logic [TAG_W-1:0] out_tag,
  output logic [15:0]      sat_count
);
  localparam int MW = INT_BITS + FRAC_BITS;
  localparam logic [MW-1:0] K_ONE    = MW'(1 << FRAC_BITS);
  localparam logic [MW-1:0] K_FIVE   = MW'(5 << FRAC_BITS);
  localparam logic [MW-1:0] K_P2375  = MW'(19 << (FRAC_BITS - 3));
  localparam logic [MW-1:0] K_P84375 = MW'(27 << (FRAC_BITS - 5));
  localparam logic [MW-1:0] K_P625   = MW'(5 << (FRAC_BITS - 3));
  localparam logic [MW-1:0] K_HALF   = MW'(1 << (FRAC_BITS - 1));
  localparam logic [1:0] MODE_SIG  = 2'b00;
  localparam logic [1:0] MODE_TANH = 2'b01;
  localparam logic [1:0] MODE_RELU = 2'b10;

  // Global stall: a held output freezes every stage.
  logic adv;
  assign adv       = !(out_valid && !out_ready);
  assign in_ready  = adv;

  // S0 unpack combinational
  logic [7:0]    x_exp;
  logic [22:0]   x_frac;
  logic [23:0]   x_mant;
  logic          x_nan;
  logic [MW-1:0] m_raw, m_d;
  int            sh;

  // Float to truncated fixed-point magnitude, with tanh prescale by 2.
  always_comb begin
    x_exp  = in_data[30:23];
    x_frac = in_data[22:0];
    x_mant = {1'b1, x_frac};
    x_nan  = (x_exp == 8'hFF) && (x_frac != 23'd0);
    sh     = int'(x_exp) - 150 + FRAC_BITS;
    if (x_exp == 8'd0)                         m_raw = '0;
    else if (int'(x_exp) >= 127 + INT_BITS)    m_raw = '1;
    else if (sh >= 0)                          m_raw = MW'(x_mant) << sh;
    else                                       m_raw = MW'(x_mant >> (-sh));
    m_d = m_raw;
    if (in_mode == MODE_TANH) m_d = m_raw[MW-1] ? '1 : {m_raw[MW-2:0], 1'b0};
  end

  logic             s0_valid_q, s0_nan_q;
  logic [1:0]       s0_mode_q;
  logic [TAG_W-1:0] s0_tag_q;
  logic [MW-1:0]    s0_mag_q;
  logic [31:0]      s0_raw_q;

  // S0 register: capture unpacked sample on input transfer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s0_valid_q <= 1'b0; s0_nan_q <= 1'b0; s0_mode_q <= '0;
      s0_tag_q <= '0; s0_mag_q <= '0; s0_raw_q <= '0;
    end else if (adv) begin
      s0_valid_q <= in_valid; s0_nan_q <= x_nan; s0_mode_q <= in_mode;
      s0_tag_q <= in_tag; s0_mag_q <= m_d; s0_raw_q <= in_data;
    end
  end

  logic [MW-1:0] g_d;

  // S1 piecewise-linear sigmoid of the magnitude.
  always_comb begin
    if (s0_mag_q >= K_FIVE)       g_d = K_ONE;
    else if (s0_mag_q >= K_P2375) g_d = (s0_mag_q >> 5) + K_P84375;
    else if (s0_mag_q >= K_ONE)   g_d = (s0_mag_q >> 3) + K_P625;
    else                          g_d = (s0_mag_q >> 2) + K_HALF;
  end

  logic             s1_valid_q, s1_nan_q;
  logic [1:0]       s1_mode_q;
  logic [TAG_W-1:0] s1_tag_q;
  logic [MW-1:0]    s1_g_q;
  logic [31:0]      s1_raw_q;

  // S1 register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0; s1_nan_q <= 1'b0; s1_mode_q <= '0;
      s1_tag_q <= '0; s1_g_q <= '0; s1_raw_q <= '0;
    end else if (adv) begin
      s1_valid_q <= s0_valid_q; s1_nan_q <= s0_nan_q; s1_mode_q <= s0_mode_q;
      s1_tag_q <= s0_tag_q; s1_g_q <= g_d; s1_raw_q <= s0_raw_q;
    end
  end

  logic          y_sign_d, y_byp_d;
  logic [MW-1:0] y_mag_d;
  logic [31:0]   y_raw_d;

  // S2 sign fold per mode; ReLU/identity bypass the raw float.
  always_comb begin
    y_sign_d = 1'b0;
    y_byp_d  = 1'b0;
    y_mag_d  = s1_g_q;
    y_raw_d  = s1_raw_q;
    case (s1_mode_q)
      MODE_SIG:  y_mag_d = s1_raw_q[31] ? (K_ONE - s1_g_q) : s1_g_q;
      MODE_TANH: begin
        y_sign_d = s1_raw_q[31];
        y_mag_d  = (s1_g_q << 1) - K_ONE;
      end
      MODE_RELU: begin
        y_byp_d = 1'b1;
        y_raw_d = s1_raw_q[31] ? 32'h0000_0000 : s1_raw_q;
      end
      default:   y_byp_d = 1'b1;
    endcase
  end

  logic             s2_valid_q, s2_nan_q, s2_sign_q, s2_byp_q;
  logic [TAG_W-1:0] s2_tag_q;
  logic [MW-1:0]    s2_mag_q;
  logic [31:0]      s2_raw_q;

  // S2 register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid_q <= 1'b0; s2_nan_q <= 1'b0; s2_sign_q <= 1'b0; s2_byp_q <= 1'b0;
      s2_tag_q <= '0; s2_mag_q <= '0; s2_raw_q <= '0;
    end else if (adv) begin
      s2_valid_q <= s1_valid_q; s2_nan_q <= s1_nan_q; s2_sign_q <= y_sign_d;
      s2_byp_q <= y_byp_d; s2_tag_q <= s1_tag_q; s2_mag_q <= y_mag_d; s2_raw_q <= y_raw_d;
    end
  end

  int            lead;
  logic [MW-1:0] norm;
  logic [22:0]   mant;
  logic [31:0]   out_data_d;

  // Normalised magnitude: bit MW-1 is the leading one (zero only when mag is zero).
  if (MW - 1 >= 23) begin : g_mant_trunc
    assign mant = norm[MW-2 -: 23];
  end else begin : g_mant_pad
    assign mant = {norm[MW-2:0], {(24 - MW){1'b0}}};
  end

  // S3 pack: leading-one normalise, truncate mantissa, NaN/bypass/zero overrides.
  always_comb begin
    lead = 0;
    for (int i = 0; i < MW; i++) if (s2_mag_q[i]) lead = i;
    norm = s2_mag_q << (MW - 1 - lead);
    if (s2_nan_q)          out_data_d = 32'h7FC0_0000;
    else if (s2_byp_q)     out_data_d = s2_raw_q;
    else if (!norm[MW-1])  out_data_d = 32'h0000_0000;
    else                   out_data_d = {s2_sign_q, 8'(127 + lead - FRAC_BITS), mant};
  end

  logic             s3_valid_q;
  logic [31:0]      out_data_q;
  logic [TAG_W-1:0] out_tag_q;

  // S3 output register; held stable while stalled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s3_valid_q <= 1'b0; out_data_q <= '0; out_tag_q <= '0;
    end else if (adv) begin
      s3_valid_q <= s2_valid_q; out_data_q <= out_data_d; out_tag_q <= s2_tag_q;
    end
  end

  assign out_valid = s3_valid_q;
  assign out_data  = out_data_q;
  assign out_tag   = out_tag_q;

`ifdef SPU_SAT_STATS_EN
  logic        sat_hit;
  logic [15:0] sat_q;
  assign sat_hit = in_valid && adv && !x_nan && (m_d >= K_FIVE) &&
                   ((in_mode == MODE_SIG) || (in_mode == MODE_TANH));

  // Saturating count of accepted sigmoid/tanh samples in the flat segment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                             sat_q <= 16'h0000;
    else if (sat_hit && sat_q != 16'hFFFF)  sat_q <= sat_q + 16'd1;
  end
  assign sat_count = sat_q;
`else
  assign sat_count = 16'h0000;
`endif

endmodule

// File: tb/tb_spu_pipe.sv
// tb/tb_spu_pipe.sv - directed self-checking bench for spu_pipe
module tb_spu_pipe;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready, out_valid, out_ready;
  logic [31:0] in_data, out_data;
  logic [1:0]  in_mode;
  logic [7:0]  in_tag, out_tag;
  logic [15:0] sat_count;

`ifdef SPU_SAT_STATS_EN
  localparam int STATS = 1;
`else
  localparam int STATS = 0;
`endif

  always #5 clk = ~clk;

  spu_pipe #(.FRAC_BITS(16), .INT_BITS(8), .TAG_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_mode(in_mode), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_tag(out_tag), .sat_count(sat_count)
  );

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  logic [31:0] got_data[$];
  logic [7:0]  got_tag[$];
  int          got_cyc[$];
  logic [31:0] exp_data[$];
  logic [7:0]  exp_tag[$];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      got_data.push_back(out_data);
      got_tag.push_back(out_tag);
      got_cyc.push_back(cyc);
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s observed=%08h expected=%08h", name, got, exp);
    end
  endtask

  task automatic send(input logic [31:0] d, input logic [1:0] m, input logic [7:0] t);
    @(posedge clk); #1;
    in_valid = 1'b1; in_data = d; in_mode = m; in_tag = t;
  endtask

  task automatic idle();
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic expect_out(input logic [31:0] d, input logic [7:0] t);
    exp_data.push_back(d);
    exp_tag.push_back(t);
  endtask

  task automatic check_stream(input string name, input bit consec);
    int n, waited;
    n = exp_data.size();
    waited = 0;
    while (got_data.size() < n && waited < 100) begin
      @(negedge clk);
      waited++;
    end
    repeat (6) @(negedge clk);
    chk($sformatf("%s_count", name), 32'(got_data.size()), 32'(n));
    for (int i = 0; i < n; i++) begin
      if (i < got_data.size()) begin
        chk($sformatf("%s_data%0d", name, i), got_data[i], exp_data[i]);
        chk($sformatf("%s_tag%0d", name, i), 32'(got_tag[i]), 32'(exp_tag[i]));
        if (consec && i > 0)
          chk($sformatf("%s_gap%0d", name, i), 32'(got_cyc[i] - got_cyc[i-1]), 32'd1);
      end
    end
    got_data.delete(); got_tag.delete(); got_cyc.delete();
    exp_data.delete(); exp_tag.delete();
  endtask

  initial begin
    int idx, low_cnt;
    bit stalled_prev;
    logic [31:0] prev_data;
    logic [7:0]  prev_tag;

    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; in_mode = '0; in_tag = '0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data", out_data, 32'h0);
    chk("rst_out_tag", 32'(out_tag), 32'd0);
    chk("rst_sat", 32'(sat_count), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);

    // Sigmoid(0) with exact 4-cycle latency
    send(32'h0000_0000, 2'b00, 8'h01);
    idle();
    repeat (2) @(negedge clk);
    @(negedge clk);
    chk("lat3_out_valid", 32'(out_valid), 32'd0);
    chk("lat3_in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    chk("lat4_out_valid", 32'(out_valid), 32'd1);
    chk("lat4_out_data", out_data, 32'h3F00_0000);
    chk("lat4_out_tag", 32'(out_tag), 32'h01);
    repeat (3) @(negedge clk);
    got_data.delete(); got_tag.delete(); got_cyc.delete();

    // Back-to-back sigmoid
    send(32'h3F80_0000, 2'b00, 8'h01); expect_out(32'h3F40_0000, 8'h01);
    send(32'hBF80_0000, 2'b00, 8'h02); expect_out(32'h3E80_0000, 8'h02);
    send(32'h4100_0000, 2'b00, 8'h03); expect_out(32'h3F80_0000, 8'h03);
    idle();
    check_stream("sig_b2b", 1'b1);
    chk("sat_after_b2b", 32'(sat_count), 32'(STATS * 1));

    // Tanh, ReLU negative, identity
    send(32'h3F00_0000, 2'b01, 8'h11); expect_out(32'h3F00_0000, 8'h11);
    send(32'hC040_0000, 2'b10, 8'h22); expect_out(32'h0000_0000, 8'h22);
    send(32'h4049_0FDB, 2'b11, 8'h33); expect_out(32'h4049_0FDB, 8'h33);
    idle();
    check_stream("modes", 1'b1);

    // Stall: out_ready low for cycles 3..8 while streaming 10 samples
    for (int i = 0; i < 10; i++) expect_out(32'h4000_0000 + 32'(i), 8'h40 + 8'(i));
    idx = 0; low_cnt = 0; stalled_prev = 1'b0; prev_data = '0; prev_tag = '0;
    for (int c = 0; c < 40; c++) begin
      @(posedge clk); #1;
      out_ready = !(c >= 3 && c <= 8);
      if (idx < 10) begin
        in_valid = 1'b1;
        in_data  = 32'h4000_0000 + 32'(idx);
        in_mode  = idx[0] ? 2'b10 : 2'b11;
        in_tag   = 8'h40 + 8'(idx);
      end else begin
        in_valid = 1'b0;
      end
      @(negedge clk);
      if (out_valid && !out_ready) begin
        chk($sformatf("stall_in_ready_c%0d", c), 32'(in_ready), 32'd0);
        if (stalled_prev) begin
          chk($sformatf("stall_data_c%0d", c), out_data, prev_data);
          chk($sformatf("stall_tag_c%0d", c), 32'(out_tag), 32'(prev_tag));
        end
      end
      stalled_prev = out_valid && !out_ready;
      prev_data = out_data;
      prev_tag  = out_tag;
      if (!in_ready) low_cnt++;
      if (in_valid && in_ready) idx++;
    end
    chk("stall_low_cycles", 32'(low_cnt), 32'd5);
    chk("stall_accepted", 32'(idx), 32'd10);
    check_stream("stall", 1'b0);

    // NaN must not count as saturated
    send(32'h7FC0_0001, 2'b00, 8'h5A); expect_out(32'h7FC0_0000, 8'h5A);
    idle();
    repeat (2) @(negedge clk);
    chk("sat_after_nan", 32'(sat_count), 32'(STATS * 1));
    check_stream("nan", 1'b0);

    // -Inf, segment boundaries, tanh saturation and negative tanh
    send(32'hFF80_0000, 2'b00, 8'h60); expect_out(32'h0000_0000, 8'h60);
    send(32'h40A0_0000, 2'b00, 8'h61); expect_out(32'h3F80_0000, 8'h61);
    send(32'h4018_0000, 2'b00, 8'h62); expect_out(32'h3F6B_0000, 8'h62);
    send(32'h4010_0000, 2'b00, 8'h63); expect_out(32'h3F68_0000, 8'h63);
    send(32'h4020_0000, 2'b01, 8'h64); expect_out(32'h3F80_0000, 8'h64);
    send(32'hBF00_0000, 2'b01, 8'h65); expect_out(32'hBF00_0000, 8'h65);
    idle();
    check_stream("edges", 1'b1);
    chk("sat_after_edges", 32'(sat_count), 32'(STATS * 4));

    // Asynchronous reset with three samples in flight
    send(32'h0000_0000, 2'b00, 8'h70);
    send(32'h0000_0000, 2'b00, 8'h71);
    send(32'h0000_0000, 2'b00, 8'h72);
    idle();
    @(posedge clk); #2;
    chk("pre_reset_out_valid", 32'(out_valid), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("async_rst_out_valid", 32'(out_valid), 32'd0);
    chk("async_rst_out_data", out_data, 32'h0);
    chk("async_rst_sat", 32'(sat_count), 32'd0);
    @(posedge clk);
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    chk("no_stale_after_reset", 32'(got_data.size()), 32'd0);
    got_data.delete(); got_tag.delete(); got_cyc.delete();
    send(32'h1234_5678, 2'b11, 8'h99); expect_out(32'h1234_5678, 8'h99);
    idle();
    check_stream("post_reset", 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
